ps2_tx_scheduler: RTL and testbench
===================================

// Module: ps2_tx_scheduler
// PURPOSE
//  Shares the single PS/2 device-to-host byte transmitter between two scancode sources:
//  port A (host-command responses: ACK/BAT/ID) and port B (translated keystroke stream).
//  Locks the grant for a whole atomic group (make/break sequence), paces bytes with a minimum
//  inter-byte gap, holds off while the host inhibits, and retries bytes the serializer aborts.
// PARAMETERS
//  GAP_CYCLES  2000  idle clk cycles enforced between end of one byte and next tx_start (>=1)
//  MAX_RETRY   3     resend attempts after tx_fail before the byte is dropped
// PORTS
//  clk        in   1  system clock
//  reset      in   1  synchronous, active-high reset
//  a_byte     in   8  port A byte
//  a_last     in   1  port A: byte ends its atomic group
//  a_valid    in   1  port A byte available
//  a_ready    out  1  port A byte accepted this cycle when a_valid&&a_ready
//  b_byte     in   8  port B byte
//  b_last     in   1  port B: byte ends its atomic group
//  b_valid    in   1  port B byte available
//  b_ready    out  1  port B accept (as a_ready)
//  inhibit    in   1  host holding PS/2 clock low / requesting to send
//  tx_data    out  8  byte to serializer
//  tx_start   out  1  1-cycle pulse: serializer begins sending tx_data
//  tx_done    in   1  1-cycle pulse: byte fully sent
//  tx_fail    in   1  1-cycle pulse: byte aborted by host inhibit
//  owner      out  2  00 none, 01 A, 10 B (current lock)
//  drop_err   out  1  1-cycle pulse: byte dropped after MAX_RETRY failures
// BEHAVIOUR
//  Reset: state FETCH, owner=00, last_grant=B, a_ready=b_ready=0, tx_start=0, tx_data=0,
//   drop_err=0, gap counter=0, retry count=0. Reset mid-byte abandons it; no tx_start after.
//  States: FETCH, START, WAIT, GAP.
//  FETCH: ready combinational: x_ready = (state==FETCH)&&!inhibit&&(owner==x || (owner==00 &&
//   arbitration picks x)). Arbitration when owner==00: only one valid -> it; both valid ->
//   port not in last_grant (round-robin). Only one ready high per cycle.
//   On accept: latch byte->tx_data, last flag, owner=x, last_grant=x, retry=0; -> START.
//  START: tx_start=1 for exactly this cycle; -> WAIT. Accept-to-tx_start latency = 1 cycle.
//  WAIT: tx_data held stable; inhibit ignored (serializer reports via tx_fail).
//   tx_done: if last flag, owner=00; load gap=GAP_CYCLES; -> GAP.
//   tx_fail: if retry<MAX_RETRY: retry++, load gap, -> GAP with resend flag set.
//    else: drop_err pulse, treat as tx_done (group continues; owner released if last).
//   tx_done and tx_fail same cycle: tx_done wins.
//  GAP: counter decrements each cycle while !inhibit; inhibit high reloads GAP_CYCLES.
//   At 0: resend flag -> START (same byte, no fetch, resend cleared); else -> FETCH.
//  Lock: while owner!=00 the other port's ready stays 0 even if it is valid; A never
//   preempts a B group mid-sequence, and vice versa.
//  Widths: gap counter $clog2(GAP_CYCLES+1) bits; retry $clog2(MAX_RETRY+1) bits; no wrap.
//  No buffering beyond one byte: upstream holds valid/byte/last until accepted.
// TESTING
//  A single byte 0xFA last=1, GAP_CYCLES=4 -> a_ready 1 cycle, tx_start next cycle with
//   tx_data=0xFA, tx_done -> owner 00, next tx_start no earlier than 5 cycles after tx_done.
//  B group 0x1C,0xF0,0x1C (last on 3rd), A valid 0xFA from 2nd byte -> a_ready stays 0 until
//   B's 3rd tx_done+gap; then 0xFA sent; tx_data order 1C,F0,1C,FA.
//  A and B valid together continuously, both last=1 -> grants alternate A,B,A,B (last_grant=B
//   after reset so A first).
//  tx_fail on byte 0x1C, MAX_RETRY=3 -> resent 3 times after gaps; 4th fail -> drop_err pulse,
//   no 5th tx_start of 0x1C, next group byte fetched.
//  inhibit high in GAP at count 2 for 10 cycles -> no tx_start; after release full GAP_CYCLES
//   elapses before tx_start; inhibit high in FETCH -> both ready 0.
//  reset asserted in WAIT -> next cycle owner=00, tx_start=0; late tx_done ignored.

Source files
------------

// File: rtl/ps2_tx_scheduler.sv
// rtl/ps2_tx_scheduler.sv - two-source PS/2 device-to-host byte scheduler
//
// Shares one PS/2 byte serializer between port A (host-command responses)
// and port B (translated keystrokes). A grant is locked for a whole atomic
// group, bytes are spaced by a minimum idle gap, the gap is restarted while
// the host inhibits, and aborted bytes are resent a bounded number of times.
//
// Ports:
//   clk, reset                 system clock, synchronous active-high reset
//   a_byte/a_last/a_valid      port A byte, end-of-group flag, byte present
//   a_ready                    port A byte taken when a_valid && a_ready
//   b_byte/b_last/b_valid      port B, same meaning as port A
//   b_ready                    port B accept
//   inhibit                    host holding PS/2 clock low
//   tx_data, tx_start          byte and 1-cycle start pulse to serializer
//   tx_done, tx_fail           serializer completion / abort pulses
//   owner                      00 none, 01 A, 10 B
//   drop_err                   1-cycle pulse when a byte is abandoned

module ps2_tx_scheduler #(
    parameter int GAP_CYCLES = 2000,
    parameter int MAX_RETRY  = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] a_byte,
    input  logic       a_last,
    input  logic       a_valid,
    output logic       a_ready,
    input  logic [7:0] b_byte,
    input  logic       b_last,
    input  logic       b_valid,
    output logic       b_ready,
    input  logic       inhibit,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_done,
    input  logic       tx_fail,
    output logic [1:0] owner,
    output logic       drop_err
);

    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [GW-1:0] GAP_LOAD  = GW'(GAP_CYCLES);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_A    = 2'b01;
    localparam logic [1:0] OWN_B    = 2'b10;

    typedef enum logic [1:0] {
        S_FETCH,
        S_START,
        S_WAIT,
        S_GAP
    } state_t;

    state_t        state_q, state_n;
    logic [1:0]    owner_q, owner_n;
    logic [1:0]    last_grant_q, last_grant_n;
    logic [7:0]    data_q, data_n;
    logic          last_q, last_n;
    logic [RW-1:0] retry_q, retry_n;
    logic [GW-1:0] gap_q, gap_n;
    logic          resend_q, resend_n;

    logic pick_a;
    logic pick_b;
    logic finish;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_FETCH;
            owner_q      <= OWN_NONE;
            last_grant_q <= OWN_B;
            data_q       <= 8'h00;
            last_q       <= 1'b0;
            retry_q      <= '0;
            gap_q        <= '0;
            resend_q     <= 1'b0;
        end else begin
            state_q      <= state_n;
            owner_q      <= owner_n;
            last_grant_q <= last_grant_n;
            data_q       <= data_n;
            last_q       <= last_n;
            retry_q      <= retry_n;
            gap_q        <= gap_n;
            resend_q     <= resend_n;
        end
    end

    // Arbitration only matters while nobody holds the lock; on a tie the
    // port that did not win last time is chosen.
    always_comb begin
        pick_a = 1'b0;
        pick_b = 1'b0;
        if (owner_q == OWN_NONE) begin
            if (a_valid && b_valid) begin
                pick_a = (last_grant_q != OWN_A);
                pick_b = (last_grant_q == OWN_A);
            end else begin
                pick_a = a_valid;
                pick_b = b_valid;
            end
        end
    end

    assign a_ready = (state_q == S_FETCH) && !inhibit && ((owner_q == OWN_A) || pick_a);
    assign b_ready = (state_q == S_FETCH) && !inhibit && ((owner_q == OWN_B) || pick_b);

    always_comb begin
        state_n      = state_q;
        owner_n      = owner_q;
        last_grant_n = last_grant_q;
        data_n       = data_q;
        last_n       = last_q;
        retry_n      = retry_q;
        gap_n        = gap_q;
        resend_n     = resend_q;
        tx_start     = 1'b0;
        drop_err     = 1'b0;
        finish       = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (a_valid && a_ready) begin
                    data_n       = a_byte;
                    last_n       = a_last;
                    owner_n      = OWN_A;
                    last_grant_n = OWN_A;
                    retry_n      = '0;
                    state_n      = S_START;
                end else if (b_valid && b_ready) begin
                    data_n       = b_byte;
                    last_n       = b_last;
                    owner_n      = OWN_B;
                    last_grant_n = OWN_B;
                    retry_n      = '0;
                    state_n      = S_START;
                end
            end
            S_START: begin
                tx_start = 1'b1;
                state_n  = S_WAIT;
            end
            S_WAIT: begin
                // Inhibit is not looked at here: the serializer reports an
                // abort through tx_fail. A simultaneous done beats fail.
                if (tx_done) begin
                    finish = 1'b1;
                end else if (tx_fail) begin
                    if (retry_q < RETRY_MAX) begin
                        retry_n  = retry_q + 1'b1;
                        gap_n    = GAP_LOAD;
                        resend_n = 1'b1;
                        state_n  = S_GAP;
                    end else begin
                        // Out of retries: abandon the byte but keep the
                        // group going as if it had been sent.
                        drop_err = 1'b1;
                        finish   = 1'b1;
                    end
                end
                if (finish) begin
                    if (last_q) begin
                        owner_n = OWN_NONE;
                    end
                    gap_n    = GAP_LOAD;
                    resend_n = 1'b0;
                    state_n  = S_GAP;
                end
            end
            S_GAP: begin
                if (inhibit) begin
                    gap_n = GAP_LOAD;
                end else if (gap_q == '0) begin
                    resend_n = 1'b0;
                    state_n  = resend_q ? S_START : S_FETCH;
                end else begin
                    gap_n = gap_q - 1'b1;
                end
            end
            default: begin
                state_n = S_FETCH;
            end
        endcase
    end

    assign tx_data = data_q;
    assign owner   = owner_q;

endmodule

// File: tb/tb_ps2_tx_scheduler.sv
// tb/tb_ps2_tx_scheduler.sv - directed self-checking bench for ps2_tx_scheduler

module tb_ps2_tx_scheduler;

    localparam int GAP = 4;
    localparam int MR  = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] a_byte = 8'h00;
    logic       a_last = 1'b0;
    logic       a_valid = 1'b0;
    logic       a_ready;
    logic [7:0] b_byte = 8'h00;
    logic       b_last = 1'b0;
    logic       b_valid = 1'b0;
    logic       b_ready;
    logic       inhibit = 1'b0;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       resp_done = 1'b0;
    logic       man_done = 1'b0;
    logic       tx_done_w;
    logic       tx_fail = 1'b0;
    logic [1:0] owner;
    logic       drop_err;

    assign tx_done_w = resp_done | man_done;

    always #5 clk = ~clk;

    ps2_tx_scheduler #(.GAP_CYCLES(GAP), .MAX_RETRY(MR)) dut (
        .clk      (clk),
        .reset    (reset),
        .a_byte   (a_byte),
        .a_last   (a_last),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .b_byte   (b_byte),
        .b_last   (b_last),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .inhibit  (inhibit),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_done  (tx_done_w),
        .tx_fail  (tx_fail),
        .owner    (owner),
        .drop_err (drop_err)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [7:0] starts[$];
    int         start_cyc[$];
    int         done_cnt = 0;
    int         done_cyc = 0;
    int         fail_left = 0;
    bit         resp_en = 1'b1;
    int         drop_cnt = 0;
    int         lock_viol = 0;
    int         a_acc_cyc = 0;
    int         b_acc_n = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Serializer model: answers each tx_start two cycles later with done
    // or, while fail_left is nonzero, with fail.
    initial forever begin
        @(negedge clk);
        if (tx_start && !reset) begin
            starts.push_back(tx_data);
            start_cyc.push_back(cyc);
            if (resp_en) begin
                repeat (2) @(posedge clk);
                #1;
                if (fail_left > 0) begin
                    tx_fail = 1'b1;
                    fail_left--;
                end else begin
                    resp_done = 1'b1;
                end
                done_cyc = cyc;
                done_cnt++;
                @(posedge clk);
                #1;
                resp_done = 1'b0;
                tx_fail   = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (drop_err) drop_cnt++;
        if ((owner == 2'b10 && a_ready) || (owner == 2'b01 && b_ready) || (a_ready && b_ready))
            lock_viol++;
    end

    task automatic push_a(input logic [7:0] d, input logic l);
        int n;
        a_byte = d; a_last = l; a_valid = 1'b1; n = 0;
        @(negedge clk);
        while (!a_ready && n < 400) begin
            n++;
            @(negedge clk);
        end
        if (!a_ready) check("a_accept_timeout", 0, 1);
        a_acc_cyc = cyc;
        @(posedge clk);
        #1 a_valid = 1'b0;
    endtask

    task automatic push_b(input logic [7:0] d, input logic l);
        int n;
        b_byte = d; b_last = l; b_valid = 1'b1; n = 0;
        @(negedge clk);
        while (!b_ready && n < 400) begin
            n++;
            @(negedge clk);
        end
        if (!b_ready) check("b_accept_timeout", 0, 1);
        b_acc_n++;
        @(posedge clk);
        #1 b_valid = 1'b0;
    endtask

    task automatic wait_starts(input int n);
        int k;
        k = 0;
        while (starts.size() < n && k < 500) begin
            k++;
            @(negedge clk);
        end
        if (starts.size() < n) check("start_timeout", starts.size(), n);
    endtask

    task automatic wait_done(input int target);
        int k;
        k = 0;
        while (done_cnt < target && k < 500) begin
            k++;
            @(negedge clk);
        end
        if (done_cnt < target) check("done_timeout", done_cnt, target);
    endtask

    task automatic check_start(input string tag, input int k, input logic [7:0] exp);
        if (starts.size() > k) check(tag, starts[k], exp);
        else check(tag, 32'hdead, exp);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        int d1, b3_done, rel, base, n0;
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int d1, b3_done, rel, base, n0;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_owner", owner, 2'b00);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_drop_err", drop_err, 0);
        check("rst_ready", {a_ready, b_ready}, 2'b00);
        @(posedge clk);
        #1 reset = 1'b0;

        // single byte, latency and gap
        push_a(8'hFA, 1'b1);
        @(negedge clk);
        check("t1_ready_1cyc", a_ready, 0);
        check("t1_start", tx_start, 1);
        check("t1_data", tx_data, 8'hFA);
        check("t1_latency", start_cyc[0] - a_acc_cyc, 1);
        fork
            push_a(8'hAA, 1'b1);
            begin
                wait_done(1);
                check("t1_owner_locked", owner, 2'b01);
                d1 = done_cyc;
                @(negedge clk);
                check("t1_owner_released", owner, 2'b00);
            end
        join
        wait_starts(2);
        check("t1_gap_min", (start_cyc[1] - d1) >= GAP + 1, 1);
        check("t1_gap_exact", start_cyc[1] - d1, 7);
        repeat (12) @(posedge clk);
        #1;

        // B group lock against A
        starts.delete(); start_cyc.delete();
        base = done_cnt; n0 = b_acc_n;
        fork
            begin
                push_b(8'h1C, 1'b0);
                push_b(8'hF0, 1'b0);
                push_b(8'h1C, 1'b1);
                wait_done(base + 3);
                b3_done = done_cyc;
            end
            begin
                while (b_acc_n < n0 + 1) @(negedge clk);
                @(posedge clk);
                #1;
                push_a(8'hFA, 1'b1);
            end
        join
        wait_starts(4);
        check_start("t2_ord0", 0, 8'h1C);
        check_start("t2_ord1", 1, 8'hF0);
        check_start("t2_ord2", 2, 8'h1C);
        check_start("t2_ord3", 3, 8'hFA);
        check("t2_a_after_gap", a_acc_cyc - b3_done, 6);
        repeat (12) @(posedge clk);
        #1;

        // round robin after reset
        do_reset();
        starts.delete(); start_cyc.delete();
        fork
            begin push_a(8'h11, 1'b1); push_a(8'h12, 1'b1); end
            begin push_b(8'h21, 1'b1); push_b(8'h22, 1'b1); end
        join
        wait_starts(4);
        check_start("t3_rr0", 0, 8'h11);
        check_start("t3_rr1", 1, 8'h21);
        check_start("t3_rr2", 2, 8'h12);
        check_start("t3_rr3", 3, 8'h22);
        repeat (12) @(posedge clk);
        #1;

        // retries and drop
        starts.delete(); start_cyc.delete();
        drop_cnt = 0;
        fail_left = 4;
        push_b(8'h1C, 1'b0);
        push_b(8'h32, 1'b1);
        wait_starts(5);
        repeat (12) @(posedge clk);
        check("t4_start_count", starts.size(), 5);
        check_start("t4_s0", 0, 8'h1C);
        check_start("t4_s1", 1, 8'h1C);
        check_start("t4_s2", 2, 8'h1C);
        check_start("t4_s3", 3, 8'h1C);
        check_start("t4_s4", 4, 8'h32);
        check("t4_drop_cnt", drop_cnt, 1);
        #1;

        // inhibit during gap restarts it
        starts.delete(); start_cyc.delete();
        base = done_cnt;
        fork
            begin push_a(8'h55, 1'b1); push_a(8'h66, 1'b1); end
            begin
                wait_done(base + 1);
                d1 = done_cyc;
                while (cyc != d1 + 3) begin
                    @(posedge clk);
                    #1;
                end
                inhibit = 1'b1;
                repeat (10) @(posedge clk);
                #1 inhibit = 1'b0;
                rel = cyc;
                check("t5_no_start_inhibit", starts.size(), 1);
                wait_starts(2);
                if (start_cyc.size() > 1) begin
                    check("t5_full_gap_min", (start_cyc[1] - rel) >= GAP, 1);
                    check("t5_full_gap_exact", start_cyc[1] - rel, 6);
                end else begin
                    check("t5_full_gap", 0, 1);
                end
            end
        join
        repeat (20) @(posedge clk);
        #1;

        // inhibit in FETCH blocks both ports
        inhibit = 1'b1;
        fork
            push_a(8'h88, 1'b1);
            begin
                repeat (3) begin
                    @(negedge clk);
                    check("t5_fetch_inhibit", {a_ready, b_ready}, 2'b00);
                end
                @(posedge clk);
                #1 inhibit = 1'b0;
            end
        join
        wait_starts(3);
        check_start("t5_after_release", 2, 8'h88);
        repeat (12) @(posedge clk);
        #1;

        // reset while waiting for the serializer
        resp_en = 1'b0;
        push_a(8'h77, 1'b1);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t6_owner", owner, 2'b00);
        check("t6_tx_start", tx_start, 0);
        check("t6_tx_data", tx_data, 8'h00);
        reset = 1'b0;
        n0 = starts.size();
        @(posedge clk);
        #1 man_done = 1'b1;
        @(posedge clk);
        #1 man_done = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("t6_no_start", starts.size(), n0);
        check("t6_owner_after", owner, 2'b00);
        resp_en = 1'b1;

        check("lock_violations", lock_viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
